// File: rtl/mem_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_seq_pkg
// Description : Shared types and helpers for the E_Mem request sequencer:
//               sequencer state encoding and byte-enable to bit-mask expansion.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_seq_pkg;

   // Sequencer states: IDLE after reset, CLEAR zero-fills the RAM,
   // RUN serves fabric requests, DRAIN waits for the last read to land.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } state_e;

   // Widest data path the mask helper supports; callers size-cast the result.
   localparam int unsigned c_MASK_MAX_W = 256;

   // Expand byte enables into a per-bit write mask (byte i -> bits 8i+7:8i).
   function automatic logic [c_MASK_MAX_W-1:0] be_expand(
      input logic [c_MASK_MAX_W/8-1:0] be
   );
      logic [c_MASK_MAX_W-1:0] mask;
      mask = '0;
      for (int i = 0; i < c_MASK_MAX_W / 8; i++) begin
         mask[8*i +: 8] = {8{be[i]}};
      end
      return mask;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mem_rsp_fifo
// Description : Synchronous response FIFO with occupancy count. The head
//               entry is read straight from the storage flops.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_rsp_fifo #(
   parameter int unsigned DEPTH = 3,
   parameter int unsigned WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push_i,
   input  logic [WIDTH-1:0]             data_i,
   input  logic                         pop_i,
   output logic [WIDTH-1:0]             data_o,
   output logic                         valid_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int unsigned            c_PTR_W    = $clog2(DEPTH);
   localparam int unsigned            c_CNT_W    = $clog2(DEPTH + 1);
   localparam logic [c_PTR_W-1:0]     c_LAST_PTR = c_PTR_W'(DEPTH - 1);
   localparam logic [c_CNT_W-1:0]     c_FULL_CNT = c_CNT_W'(DEPTH);

   logic [WIDTH-1:0]   storage_q [DEPTH];
   logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [c_CNT_W-1:0] count_q, count_d;
   logic               w_pop;

   // A pop on an empty FIFO is ignored; a push at full is only legal with a pop.
   assign w_pop   = pop_i && (count_q != '0);
   assign valid_o = (count_q != '0);
   assign data_o  = storage_q[rd_ptr_q];
   assign count_o = count_q;

   // Pointer wrap and occupancy update.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) begin
         wr_ptr_d = (wr_ptr_q == c_LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
         rd_ptr_d = (rd_ptr_q == c_LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push_i, w_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage and pointer registers; reset empties the FIFO and zeroes the head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            storage_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            storage_q[wr_ptr_q] <= data_i;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push_i && !w_pop && (count_q == c_FULL_CNT)));

endmodule
`default_nettype wire

// File: rtl/mem_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_sequencer
// Description : Request front-end for the E_Mem 2**ADDR_W x DATA_W simple
//               dual-port RAM. Zero-fills the RAM after reset / on clear_req,
//               maps valid/ready requests onto the RAM ports and returns read
//               data through a credit-managed response FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_sequencer
   import mem_seq_pkg::*;
#(
   parameter int unsigned ADDR_W    = 4,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned RSP_DEPTH = 3
) (
   input  logic                UserCLK,
   input  logic                resetn,
   // fabric request stream
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   // read response stream
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   // control / status
   input  logic                clear_req,
   output logic                init_done,
   // RAM ports
   output logic [ADDR_W-1:0]   mem_rd_addr,
   output logic                mem_rd_en,
   input  logic [DATA_W-1:0]   mem_rd_data,
   output logic [ADDR_W-1:0]   mem_wr_addr,
   output logic [DATA_W-1:0]   mem_wr_data,
   output logic [DATA_W-1:0]   mem_wr_en
);

   localparam int unsigned         c_BE_W      = DATA_W / 8;
   localparam int unsigned         c_CNT_W     = $clog2(RSP_DEPTH + 1);
   localparam logic [ADDR_W-1:0]   c_LAST_ADDR = '1;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
   logic                inflight_q, inflight_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;

   logic [c_CNT_W-1:0]  w_fifo_count;
   logic [c_CNT_W:0]    w_occupancy;
   logic                w_credit;
   logic                w_accept;
   logic [DATA_W-1:0]   w_be_mask;

   // Read credit: reserved slots are queued entries plus the read in flight.
   // A pop in the same cycle deliberately does not free a slot.
   assign w_occupancy = {1'b0, w_fifo_count} + {{c_CNT_W{1'b0}}, inflight_q};
   assign w_credit    = (w_occupancy < (c_CNT_W + 1)'(RSP_DEPTH));
   assign w_accept    = req_valid && req_ready;
   assign w_be_mask   = DATA_W'(be_expand((c_MASK_MAX_W / 8)'(req_be)));

   // Next-state, clear counter and RAM port muxing.
   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      req_ready   = 1'b0;
      init_done   = 1'b0;
      mem_rd_en   = 1'b0;
      mem_wr_addr = '0;
      mem_wr_data = '0;
      mem_wr_en   = '0;
      case (state_q)
         IDLE: begin
            clr_cnt_d = '0;
            state_d   = CLEAR;
         end
         CLEAR: begin
            mem_wr_addr = clr_cnt_q;
            mem_wr_en   = '1;
            clr_cnt_d   = clr_cnt_q + 1'b1;
            if (clr_cnt_q == c_LAST_ADDR) begin
               state_d = RUN;
            end
         end
         RUN: begin
            init_done = 1'b1;
            if (clear_req) begin
               state_d = DRAIN;
            end else begin
               req_ready = req_we || w_credit;
            end
            if (w_accept) begin
               if (req_we) begin
                  mem_wr_addr = req_addr;
                  mem_wr_data = req_wdata;
                  mem_wr_en   = w_be_mask;
               end else begin
                  mem_rd_en = 1'b1;
               end
            end
         end
         DRAIN: begin
            clr_cnt_d = '0;
            if (!inflight_q) begin
               state_d = CLEAR;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The read address is driven live on an accepted read and held otherwise.
   assign mem_rd_addr = mem_rd_en ? req_addr : rd_addr_q;
   assign rd_addr_d   = mem_rd_addr;
   assign inflight_d  = mem_rd_en;

   // Control state registers.
   always_ff @(posedge UserCLK or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         clr_cnt_q  <= '0;
         inflight_q <= 1'b0;
         rd_addr_q  <= '0;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         inflight_q <= inflight_d;
         rd_addr_q  <= rd_addr_d;
      end
   end

   // RAM data is valid the cycle after the read strobe: push it then.
   mem_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .WIDTH (DATA_W)
   ) u_rsp_fifo (
      .clk     (UserCLK),
      .rst_n   (resetn),
      .push_i  (inflight_q),
      .data_i  (mem_rd_data),
      .pop_i   (rsp_ready),
      .data_o  (rsp_rdata),
      .valid_o (rsp_valid),
      .count_o (w_fifo_count)
   );

   // The byte-enable bus width is only meaningful for whole bytes.
   if ((DATA_W % 8) != 0 || c_BE_W == 0 || DATA_W > c_MASK_MAX_W || RSP_DEPTH < 2)
   begin : g_bad_params
      a_params: assert property (@(posedge UserCLK) 1'b0);
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_req_sequencer
// Description : Self-checking bench for mem_req_sequencer with a RAM model,
//               a shadow memory and an expected-response queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_req_sequencer;

   localparam int ADDR_W    = 4;
   localparam int DATA_W    = 32;
   localparam int RSP_DEPTH = 3;
   localparam int WORDS     = 16;

   logic              UserCLK = 1'b0;
   logic              resetn  = 1'b1;
   logic              req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0, clear_req = 1'b0;
   logic [3:0]        req_addr = '0, req_be = '0;
   logic [31:0]       req_wdata = '0;
   logic              req_ready, rsp_valid, init_done, mem_rd_en;
   logic [31:0]       rsp_rdata, mem_rd_data, mem_wr_data, mem_wr_en;
   logic [3:0]        mem_rd_addr, mem_wr_addr;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct packed {
      logic [31:0] data;
      int          acc;
   } rsp_t;

   rsp_t        exp_q[$];
   logic [31:0] shadow [WORDS];
   logic [31:0] ram    [WORDS];

   wire [107:0] all_outs = {req_ready, rsp_valid, rsp_rdata, init_done, mem_rd_addr,
                            mem_rd_en, mem_wr_addr, mem_wr_data, mem_wr_en};

   always #5 UserCLK = ~UserCLK;

   mem_req_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RSP_DEPTH(RSP_DEPTH)) dut (
      .UserCLK(UserCLK), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .clear_req(clear_req), .init_done(init_done),
      .mem_rd_addr(mem_rd_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
      .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en)
   );

   // RAM model: sync read, non-transparent, per-bit write enable.
   initial begin
      for (int i = 0; i < WORDS; i++) ram[i] = $urandom;
      mem_rd_data = '0;
   end
   always @(posedge UserCLK) begin
      if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
      ram[mem_wr_addr] <= (ram[mem_wr_addr] & ~mem_wr_en) | (mem_wr_data & mem_wr_en);
   end

   function automatic logic [31:0] be_mask(input logic [3:0] be);
      logic [31:0] m = 32'h0;
      for (int i = 0; i < 4; i++) if (be[i]) m = m | (32'hFF << (8 * i));
      return m;
   endfunction

   // Drive one cycle's inputs just after the falling edge, leaving time to sample.
   task automatic drive(input logic v, input logic we, input logic [3:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        input logic rr, input logic cl);
      @(negedge UserCLK);
      cyc++;
      req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_be = be;
      rsp_ready = rr; clear_req = cl;
      #1;
   endtask

   // Advance the reference model by the handshakes seen this cycle.
   task automatic commit();
      rsp_t e;
      if (req_valid && req_ready) begin
         if (req_we) shadow[req_addr] = (shadow[req_addr] & ~be_mask(req_be)) | (req_wdata & be_mask(req_be));
         else begin
            e.data = shadow[req_addr];
            e.acc  = cyc;
            exp_q.push_back(e);
         end
      end
      if (rsp_valid && rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
   endtask

   task automatic test_reset();
      #1 resetn = 1'b0;
      drive(1, 1, 4'h7, 32'hDEAD_BEEF, 4'hF, 1, 1);
      checks++;
      if (all_outs !== '0) begin
         errors++; $display("FAIL reset_outputs: got %h expected 0", all_outs);
      end
      @(negedge UserCLK); cyc++; resetn = 1'b1; #1;
      checks++;
      if ({req_ready, mem_wr_en, init_done} !== '0) begin
         errors++; $display("FAIL idle_after_release: ready=%b wr_en=%h init=%b expected 0", req_ready, mem_wr_en, init_done);
      end
      for (int k = 0; k < WORDS; k++) begin
         drive(1, 1'($urandom), 4'($urandom), $urandom, 4'hF, 1, 1'($urandom));
         checks++;
         if ({mem_wr_addr, mem_wr_data, mem_wr_en, req_ready, init_done, mem_rd_en} !==
             {4'(k), 32'h0, 32'hFFFF_FFFF, 3'b000}) begin
            errors++; $display("FAIL clear_write_%0d: addr=%h data=%h en=%h ready=%b init=%b rd=%b expected addr=%h 0 ffffffff 0 0 0",
                               k, mem_wr_addr, mem_wr_data, mem_wr_en, req_ready, init_done, mem_rd_en, 4'(k));
         end
      end
      drive(0, 1, 0, 0, 0, 1, 0);
      checks++;
      if ({init_done, req_ready} !== 2'b11) begin
         errors++; $display("FAIL init_done_cycle17: init=%b ready=%b expected 1 1", init_done, req_ready);
      end
      for (int i = 0; i < WORDS; i++) shadow[i] = 32'h0;
      exp_q.delete();
   endtask

   task automatic test_write_read();
      drive(1, 1, 4'd3, 32'hA5A5_5A5A, 4'hF, 1, 0);
      checks++;
      if ({req_ready, mem_wr_addr, mem_wr_data, mem_wr_en, mem_rd_en} !== {1'b1, 4'd3, 32'hA5A5_5A5A, 32'hFFFF_FFFF, 1'b0}) begin
         errors++; $display("FAIL wr3: ready=%b addr=%h data=%h en=%h rd=%b expected 1 3 a5a55a5a ffffffff 0",
                            req_ready, mem_wr_addr, mem_wr_data, mem_wr_en, mem_rd_en);
      end
      commit();
      drive(1, 0, 4'd3, 0, 0, 1, 0);
      checks++;
      if ({req_ready, mem_rd_en, mem_rd_addr, mem_wr_en} !== {1'b1, 1'b1, 4'd3, 32'h0}) begin
         errors++; $display("FAIL rd3_issue: ready=%b rd=%b addr=%h wr_en=%h expected 1 1 3 0", req_ready, mem_rd_en, mem_rd_addr, mem_wr_en);
      end
      commit();
      drive(0, 0, 0, 0, 0, 1, 0);
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++; $display("FAIL rd3_early: rsp_valid=%b expected 0", rsp_valid);
      end
      commit();
      drive(0, 0, 0, 0, 0, 1, 0);
      checks++;
      if ({rsp_valid, rsp_rdata} !== {1'b1, 32'hA5A5_5A5A}) begin
         errors++; $display("FAIL rd3_data: valid=%b data=%h expected 1 a5a55a5a", rsp_valid, rsp_rdata);
      end
      commit();
      drive(0, 0, 0, 0, 0, 1, 0);
      checks++;
      if ({rsp_valid, mem_rd_en, mem_rd_addr} !== {1'b0, 1'b0, 4'd3}) begin
         errors++; $display("FAIL rd3_after: valid=%b rd=%b addr=%h expected 0 0 3", rsp_valid, mem_rd_en, mem_rd_addr);
      end
      commit();
   endtask

   task automatic test_byte_enable();
      drive(1, 1, 4'd5, 32'h1122_3344, 4'b0101, 1, 0);
      checks++;
      if ({req_ready, mem_wr_en} !== {1'b1, 32'h00FF_00FF}) begin
         errors++; $display("FAIL be_mask: ready=%b en=%h expected 1 00ff00ff", req_ready, mem_wr_en);
      end
      commit();
      drive(1, 1, 4'd5, 32'hFFFF_FFFF, 4'h0, 1, 0);
      checks++;
      if ({req_ready, mem_wr_en} !== {1'b1, 32'h0}) begin
         errors++; $display("FAIL be_zero: ready=%b en=%h expected 1 0", req_ready, mem_wr_en);
      end
      commit();
      drive(1, 0, 4'd5, 0, 0, 1, 0);
      commit();
      drive(0, 0, 0, 0, 0, 1, 0);
      commit();
      drive(0, 0, 0, 0, 0, 1, 0);
      checks++;
      if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h0022_0044}) begin
         errors++; $display("FAIL be_readback: valid=%b data=%h expected 1 00220044", rsp_valid, rsp_rdata);
      end
      commit();
   endtask

   task automatic test_random_traffic(input int n);
      logic v, we, rr, exp_ready, exp_valid;
      logic [3:0] a, be;
      logic [31:0] d;
      for (int i = 0; i < n; i++) begin
         v = ($urandom_range(0, 3) != 0); we = 1'($urandom); a = 4'($urandom);
         d = $urandom; be = 4'($urandom); rr = ($urandom_range(0, 3) != 0);
         drive(v, we, a, d, be, rr, 0);
         exp_ready = we || (exp_q.size() < RSP_DEPTH);
         exp_valid = (exp_q.size() > 0) && (cyc >= exp_q[0].acc + 2);
         checks++;
         if ({req_ready, rsp_valid} !== {exp_ready, exp_valid}) begin
            errors++; $display("FAIL rand_hs cyc %0d: ready=%b valid=%b expected %b %b", cyc, req_ready, rsp_valid, exp_ready, exp_valid);
         end
         if (exp_valid) begin
            checks++;
            if (rsp_rdata !== exp_q[0].data) begin
               errors++; $display("FAIL rand_rdata cyc %0d: got %h expected %h", cyc, rsp_rdata, exp_q[0].data);
            end
         end
         checks++;
         if (v && exp_ready && we) begin
            if ({mem_wr_addr, mem_wr_data, mem_wr_en, mem_rd_en} !== {a, d, be_mask(be), 1'b0}) begin
               errors++; $display("FAIL rand_wr cyc %0d: addr=%h data=%h en=%h rd=%b expected %h %h %h 0",
                                  cyc, mem_wr_addr, mem_wr_data, mem_wr_en, mem_rd_en, a, d, be_mask(be));
            end
         end else if (v && exp_ready) begin
            if ({mem_rd_en, mem_rd_addr, mem_wr_en} !== {1'b1, a, 32'h0}) begin
               errors++; $display("FAIL rand_rd cyc %0d: rd=%b addr=%h wr_en=%h expected 1 %h 0", cyc, mem_rd_en, mem_rd_addr, mem_wr_en, a);
            end
         end else if ({mem_rd_en, mem_wr_en} !== 33'h0) begin
            errors++; $display("FAIL rand_idle cyc %0d: rd=%b wr_en=%h expected 0 0", cyc, mem_rd_en, mem_wr_en);
         end
         commit();
      end
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
         drive(0, 0, 0, 0, 0, 1, 0);
         if (rsp_valid) begin
            checks++;
            if (rsp_rdata !== exp_q[0].data) begin
               errors++; $display("FAIL drain_rdata: got %h expected %h", rsp_rdata, exp_q[0].data);
            end
         end
         commit();
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL drain_timeout: %0d responses outstanding expected 0", exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      int acc = 0;
      for (int i = 0; i < 6; i++) begin
         drive(1, 0, 4'($urandom), 0, 0, 0, 0);
         checks++;
         if (req_ready !== (i < 3)) begin
            errors++; $display("FAIL bp_ready_%0d: got %b expected %b", i, req_ready, (i < 3));
         end
         if (req_ready) acc++;
         commit();
      end
      checks++;
      if (acc != 3) begin
         errors++; $display("FAIL bp_accepted: got %0d expected 3", acc);
      end
      drive(1, 1, 4'd9, $urandom, 4'hF, 0, 0);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL bp_write: ready=%b expected 1", req_ready);
      end
      commit();
      for (int j = 0; j < 3; j++) begin
         drive(0, 0, 0, 0, 0, 1, 0);
         checks++;
         if (exp_q.size() == 0 || {rsp_valid, rsp_rdata} !== {1'b1, exp_q[0].data}) begin
            errors++; $display("FAIL bp_rsp_%0d: valid=%b data=%h expected 1 %h", j, rsp_valid, rsp_rdata,
                               (exp_q.size() > 0) ? exp_q[0].data : 32'h0);
         end
         commit();
      end
      drive(0, 0, 0, 0, 0, 1, 0);
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++; $display("FAIL bp_empty: valid=%b expected 0", rsp_valid);
      end
      commit();
   endtask

   task automatic test_clear_inflight();
      int got = 0;
      drive(1, 0, 4'd3, 0, 0, 1, 0);
      commit();
      drive(1, 0, 4'd5, 0, 0, 1, 1);
      checks++;
      if ({req_ready, init_done} !== 2'b01) begin
         errors++; $display("FAIL clr_req_cycle: ready=%b init=%b expected 0 1", req_ready, init_done);
      end
      commit();
      drive(1, 1, 4'd2, 32'h1234_5678, 4'hF, 1, 0);
      checks++;
      if ({init_done, req_ready, mem_wr_en} !== 34'h0 || exp_q.size() == 0 ||
          {rsp_valid, rsp_rdata} !== {1'b1, exp_q[0].data}) begin
         errors++; $display("FAIL drain_cycle: init=%b ready=%b en=%h valid=%b data=%h expected 0 0 0 1 %h",
                            init_done, req_ready, mem_wr_en, rsp_valid, rsp_rdata, (exp_q.size() > 0) ? exp_q[0].data : 32'h0);
      end
      commit();
      for (int k = 0; k < WORDS; k++) begin
         drive(1, 1'($urandom), 4'($urandom), $urandom, 4'hF, 1, 1'($urandom));
         checks++;
         if ({mem_wr_addr, mem_wr_data, mem_wr_en, req_ready} !== {4'(k), 32'h0, 32'hFFFF_FFFF, 1'b0}) begin
            errors++; $display("FAIL reclear_%0d: addr=%h data=%h en=%h ready=%b expected %h 0 ffffffff 0",
                               k, mem_wr_addr, mem_wr_data, mem_wr_en, req_ready, 4'(k));
         end
         commit();
      end
      for (int i = 0; i < WORDS; i++) shadow[i] = 32'h0;
      for (int i = 0; i < 8; i++) begin
         drive(i < 4, 0, 4'($urandom), 0, 0, 1, 0);
         if (rsp_valid) begin
            got++;
            checks++;
            if (rsp_rdata !== 32'h0) begin
               errors++; $display("FAIL post_clear_read: got %h expected 0", rsp_rdata);
            end
         end
         commit();
      end
      checks++;
      if (got != 4) begin
         errors++; $display("FAIL post_clear_count: got %0d expected 4", got);
      end
   endtask

   task automatic test_reset_midstream();
      drive(1, 0, 4'd1, 0, 0, 0, 0); commit();
      drive(1, 0, 4'd2, 0, 0, 0, 0); commit();
      drive(0, 0, 0, 0, 0, 0, 0);    commit();
      drive(0, 0, 0, 0, 0, 0, 0);    commit();
      checks++;
      if ({rsp_valid, exp_q.size() == 2} !== 2'b11) begin
         errors++; $display("FAIL midstream_queued: valid=%b model=%0d expected 1 2", rsp_valid, exp_q.size());
      end
      @(negedge UserCLK); cyc++;
      resetn = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; req_wdata = 32'hFFFF_FFFF; rsp_ready = 1'b1;
      #1;
      checks++;
      if (all_outs !== '0) begin
         errors++; $display("FAIL midstream_reset: got %h expected 0", all_outs);
      end
      exp_q.delete();
      @(negedge UserCLK); cyc++;
      @(negedge UserCLK); cyc++; resetn = 1'b1; #1;
      checks++;
      if ({mem_wr_en, init_done, req_ready} !== 34'h0) begin
         errors++; $display("FAIL restart_idle: en=%h init=%b ready=%b expected 0 0 0", mem_wr_en, init_done, req_ready);
      end
      drive(0, 0, 0, 0, 0, 1, 0);
      checks++;
      if ({mem_wr_addr, mem_wr_en} !== {4'd0, 32'hFFFF_FFFF}) begin
         errors++; $display("FAIL restart_clear: addr=%h en=%h expected 0 ffffffff", mem_wr_addr, mem_wr_en);
      end
      for (int k = 1; k < WORDS; k++) drive(0, 0, 0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0, 1, 0);
      checks++;
      if (init_done !== 1'b1) begin
         errors++; $display("FAIL restart_run: init=%b expected 1", init_done);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_enable();
      test_random_traffic(400);
      test_backpressure();
      test_clear_inflight();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
